// File: rtl/heap_sift_ctrl.sv
// Binary min-heap controller over an external dual-port RAM (combinational read, synchronous write).
// Insert sifts up from the new leaf; pop returns the root and sifts the last entry down from the root.
module heap_sift_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_data_a,
  output logic                  ram_we_a,
  input  logic [DATA_WIDTH-1:0] ram_q_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_data_b,
  output logic                  ram_we_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b
);

  localparam int IW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] CAP = '1;

  typedef enum logic [1:0] {IDLE, UP, DN_RD, DN_WR} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   count_q;
  logic [IW-1:0]           i_q, c_q;
  logic [DATA_WIDTH-1:0]   v_q, cv_q;
  logic                    rsp_valid_q, rsp_err_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;

  // Index math at IW bits so 2i / 2i+1 never wrap before the bound check.
  logic [IW-1:0] cnt_x, left_x, right_x;
  logic          has_left, has_right, pick_r, up_done, accept;

  assign cnt_x     = {1'b0, count_q};
  assign left_x    = {i_q[IW-2:0], 1'b0};
  assign right_x   = {i_q[IW-2:0], 1'b1};
  assign has_left  = (left_x <= cnt_x);
  assign has_right = (right_x <= cnt_x);
  assign pick_r    = has_right && (ram_q_b < ram_q_a);
  assign up_done   = (i_q == IW'(1)) || (ram_q_a <= v_q);
  assign accept    = cmd_valid && (state_q == IDLE);

  assign cmd_ready = (state_q == IDLE);
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CAP);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

  // Port B writes only while climbing, port A only while sinking, so the two never collide.
  always_comb begin
    ram_addr_a = '0;
    ram_data_a = '0;
    ram_we_a   = 1'b0;
    ram_addr_b = '0;
    ram_data_b = '0;
    ram_we_b   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && cmd_op && !empty) begin
          ram_addr_a = ADDR_WIDTH'(1);
          ram_addr_b = count_q;
        end
      end
      UP: begin
        ram_addr_a = i_q[IW-1:1];
        ram_addr_b = i_q[ADDR_WIDTH-1:0];
        ram_data_b = up_done ? v_q : ram_q_a;
        ram_we_b   = 1'b1;
      end
      DN_RD: begin
        if (has_left) begin
          ram_addr_a = left_x[ADDR_WIDTH-1:0];
          ram_addr_b = right_x[ADDR_WIDTH-1:0];
        end else begin
          ram_addr_a = i_q[ADDR_WIDTH-1:0];
          ram_data_a = v_q;
          ram_we_a   = 1'b1;
        end
      end
      DN_WR: begin
        ram_addr_a = i_q[ADDR_WIDTH-1:0];
        ram_data_a = (cv_q < v_q) ? cv_q : v_q;
        ram_we_a   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      i_q         <= '0;
      c_q         <= '0;
      v_q         <= '0;
      cv_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (!cmd_op) begin
              if (full) begin
                rsp_err_q <= 1'b1;
              end else begin
                count_q <= count_q + ADDR_WIDTH'(1);
                v_q     <= cmd_data;
                i_q     <= cnt_x + IW'(1);
                state_q <= UP;
              end
            end else if (empty) begin
              rsp_err_q <= 1'b1;
            end else begin
              rsp_data_q  <= ram_q_a;
              rsp_valid_q <= 1'b1;
              count_q     <= count_q - ADDR_WIDTH'(1);
              if (count_q != ADDR_WIDTH'(1)) begin
                v_q     <= ram_q_b;
                i_q     <= IW'(1);
                state_q <= DN_RD;
              end
            end
          end
        end
        UP: begin
          if (up_done) state_q <= IDLE;
          else         i_q     <= i_q >> 1;
        end
        DN_RD: begin
          if (!has_left) begin
            state_q <= IDLE;
          end else begin
            c_q     <= pick_r ? right_x : left_x;
            cv_q    <= pick_r ? ram_q_b : ram_q_a;
            state_q <= DN_WR;
          end
        end
        DN_WR: begin
          if (cv_q < v_q) begin
            i_q     <= c_q;
            state_q <= DN_RD;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
